// File: rtl/tdm_demux_2ch_if.sv
// Serial link bundle for the two-channel TDM demux.
// slave = demux side, master = link driver / consumer side.
interface tdm_demux_2ch_if #(
  parameter int WORD_W = 8
) ();
  logic              din;
  logic              din_en;
  logic              sync;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic              a_valid;
  logic              b_valid;
  logic              frame_err;
  logic              locked;

  modport slave (
    input  din, din_en, sync,
    output a_word, b_word, a_valid, b_valid,
    output frame_err, locked
  );

  modport master (
    output din, din_en, sync,
    input  a_word, b_word, a_valid, b_valid,
    input  frame_err, locked
  );
endinterface

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM demultiplexer: hunts frame sync, deserialises
// A then B words MSB-first, flags framing errors.
module tdm_demux_2ch #(
  parameter int WORD_W = 8
) (
  input logic             clk,
  input logic             rst,
  tdm_demux_2ch_if.slave  bus
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  typedef enum logic [1:0] {
    HUNT,
    CH_A,
    CH_B
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-2:0] sr_q, sr_d;
  logic [WORD_W-1:0] a_word_q, a_word_d;
  logic [WORD_W-1:0] b_word_q, b_word_d;
  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              locked_q, locked_d;
  logic [WORD_W-1:0] shifted;

  assign shifted = {sr_q, bus.din};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    a_word_d    = a_word_q;
    b_word_d    = b_word_q;
    a_valid_d   = 1'b0;
    b_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    if (bus.din_en) begin
      if (bus.sync) begin
        // Sync anywhere except the expected frame start aborts the frame.
        frame_err_d = !(state_q == HUNT ||
                        (state_q == CH_A && cnt_q == '0));
        state_d = CH_A;
        cnt_d   = CW'(1);
        sr_d    = shifted[WORD_W-2:0];
      end else if (state_q == CH_A && cnt_q == '0) begin
        frame_err_d = 1'b1;
        state_d     = HUNT;
        cnt_d       = '0;
      end else if (state_q != HUNT && cnt_q == LAST) begin
        cnt_d = '0;
        sr_d  = shifted[WORD_W-2:0];
        if (state_q == CH_A) begin
          a_word_d  = shifted;
          a_valid_d = 1'b1;
          state_d   = CH_B;
        end else begin
          b_word_d  = shifted;
          b_valid_d = 1'b1;
          state_d   = CH_A;
        end
      end else if (state_q != HUNT) begin
        sr_d  = shifted[WORD_W-2:0];
        cnt_d = cnt_q + 1'b1;
      end
    end
    locked_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      sr_q        <= '0;
      a_word_q    <= '0;
      b_word_q    <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      a_word_q    <= a_word_d;
      b_word_q    <= b_word_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.a_word    = a_word_q;
  assign bus.b_word    = b_word_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.b_valid   = b_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = locked_q;
endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Directed bench for tdm_demux_2ch with an event scoreboard
// keyed on the cycle each pulse must appear.
module tb_tdm_demux_2ch;
  localparam int W = 8;
  localparam int K_A = 1;
  localparam int K_B = 2;
  localparam int K_E = 3;

  typedef struct {
    int         kind;
    logic [7:0] word;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  tdm_demux_2ch_if #(.WORD_W(W)) bus ();

  tdm_demux_2ch #(.WORD_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic d, input logic s, input logic en);
    @(posedge clk);
    #1;
    bus.din    = d;
    bus.sync   = s;
    bus.din_en = en;
  endtask

  task automatic push(input int kind, input logic [7:0] w);
    exp_t e;
    e.kind = kind;
    e.word = w;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input logic first_sync,
                           input int kind, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      if (gap && i != 7) idle();
      drive(w[i], first_sync && i == 7, 1'b1);
      if (first_sync && !gap && i == 6) begin
        @(negedge clk);
        chk("locked_after_sync", 32'(bus.locked), 32'd1);
      end
    end
    push(kind, w);
  endtask

  // Scoreboard: every pulse must match the head entry, in its cycle.
  always @(negedge clk) begin
    if (!rst) begin
      int   n;
      int   k;
      exp_t e;
      n = int'(bus.a_valid) + int'(bus.b_valid) + int'(bus.frame_err);
      checks++;
      assert (n <= 1) else begin
        errors++;
        $error("FAIL onehot obs=%0d exp<=1", n);
      end
      if (n != 0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pulse obs=%0d%0d%0d exp=none cyc=%0d",
                 bus.a_valid, bus.b_valid, bus.frame_err, cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          k = bus.a_valid ? K_A : (bus.b_valid ? K_B : K_E);
          chk("pulse_kind", 32'(k), 32'(e.kind));
          chk("pulse_cyc", 32'(cyc), 32'(e.cyc));
          if (e.kind != K_E)
            chk("pulse_word",
                32'(bus.a_valid ? bus.a_word : bus.b_word),
                32'(e.word));
        end
      end else if (sb.size() != 0) begin
        checks++;
        assert (sb[0].cyc > cyc) else begin
          errors++;
          $error("FAIL missing_pulse obs=none exp_kind=%0d cyc=%0d",
                 sb[0].kind, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bus.din    = 1'b0;
    bus.sync   = 1'b0;
    bus.din_en = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.din    = 1'($urandom);
      bus.sync   = 1'($urandom);
      bus.din_en = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs",
          32'({bus.a_word, bus.b_word, bus.a_valid, bus.b_valid,
               bus.frame_err, bus.locked}), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      drive(1'($urandom), 1'b0, 1'($urandom));
    @(negedge clk);
    chk("nosync_locked", 32'(bus.locked), 32'd0);
    chk("nosync_aword", 32'(bus.a_word), 32'd0);

    // Clean frame, continuous.
    send_word(8'hA5, 1'b1, K_A, 1'b0);
    send_word(8'h3C, 1'b0, K_B, 1'b0);

    // Gapped frame.
    send_word(8'hA5, 1'b1, K_A, 1'b1);
    send_word(8'h3C, 1'b0, K_B, 1'b1);

    // Mid-frame sync on 4th bit of B.
    send_word(8'h11, 1'b1, K_A, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    push(K_E, 8'h00);
    for (int i = 6; i >= 0; i--)
      drive(1'(8'hF0 >> i), 1'b0, 1'b1);
    push(K_A, 8'hF0);
    idle();
    @(negedge clk);
    chk("midsync_aword", 32'(bus.a_word), 32'hF0);
    chk("midsync_bword", 32'(bus.b_word), 32'h3C);
    send_word(8'h5A, 1'b0, K_B, 1'b0);

    // Lost sync at the expected frame start.
    drive(1'b1, 1'b0, 1'b1);
    push(K_E, 8'h00);
    idle();
    @(negedge clk);
    chk("lost_locked", 32'(bus.locked), 32'd0);
    for (int i = 0; i < 16; i++)
      drive(1'($urandom), 1'b0, 1'b1);
    @(negedge clk);
    chk("lost_still_unlocked", 32'(bus.locked), 32'd0);
    send_word(8'hC3, 1'b1, K_A, 1'b0);
    send_word(8'h96, 1'b0, K_B, 1'b0);

    // Async reset after 5 bits of A.
    for (int i = 7; i >= 3; i--)
      drive(1'(8'hE7 >> i), i == 7, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        32'({bus.a_word, bus.b_word, bus.a_valid, bus.b_valid,
             bus.frame_err, bus.locked}), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 2; i >= 0; i--)
      drive(1'(8'hE7 >> i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      drive(1'($urandom), 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_locked", 32'(bus.locked), 32'd0);
    chk("post_rst_aword", 32'(bus.a_word), 32'd0);
    send_word(8'h81, 1'b1, K_A, 1'b0);
    send_word(8'h7E, 1'b0, K_B, 1'b0);

    for (int i = 0; i < 4; i++) idle();
    @(negedge clk);
    chk("final_bword", 32'(bus.b_word), 32'h7E);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
